// File: rtl/icache_fill_unit.sv
// Instruction-cache fill engine: bursts word reads from external memory with a
// bounded number of requests in flight and writes in-order responses into the cache RAM.
module icache_fill_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0]     dst_addr,
  input  logic [ADDR_WIDTH:0]       count,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
  output logic [ADDR_WIDTH-1:0]     wa,
  output logic                      we,
  output logic [DATA_WIDTH-1:0]     di
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_FILL      = 2'd1;
  localparam logic [1:0] S_DONE_ZERO = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0]     dst_q, dst_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CNT_W-1:0]          issued_q, issued_d;
  logic [CNT_W-1:0]          received_q, received_d;
  logic [OUT_W-1:0]          outstanding_q, outstanding_d;
  logic                      done_q, done_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     wa_q, wa_d;
  logic [DATA_WIDTH-1:0]     di_q, di_d;

  logic req_fire;
  logic rsp_accept;

  assign busy          = (state_q == S_FILL);
  assign done          = done_q;
  assign mem_req_valid = busy && (issued_q < count_q) && (outstanding_q < MAX_OUT);
  assign mem_req_addr  = base_q + MEM_ADDR_WIDTH'(issued_q);
  assign wa            = wa_q;
  assign we            = we_q;
  assign di            = di_q;

  assign req_fire   = mem_req_valid && mem_req_ready;
  // Responses with nothing in flight belong to an aborted fill and are dropped.
  assign rsp_accept = busy && mem_rsp_valid && (outstanding_q != '0);

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    dst_d         = dst_q;
    count_d       = count_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    done_d        = 1'b0;
    we_d          = 1'b0;
    wa_d          = wa_q;
    di_d          = di_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            base_d        = base_addr;
            dst_d         = dst_addr;
            count_d       = count;
            issued_d      = '0;
            received_d    = '0;
            outstanding_d = '0;
            state_d       = S_FILL;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE_ZERO;
          end
        end
      end
      S_DONE_ZERO: state_d = S_IDLE;
      S_FILL: begin
        if (req_fire) issued_d = issued_q + CNT_W'(1);
        case ({req_fire, rsp_accept})
          2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
          2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
          default: outstanding_d = outstanding_q;
        endcase
        if (rsp_accept) begin
          we_d       = 1'b1;
          wa_d       = dst_q + received_q[ADDR_WIDTH-1:0];
          di_d       = mem_rsp_data;
          received_d = received_q + CNT_W'(1);
          // The last write and the done pulse land in the same cycle.
          if (received_d == count_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      dst_q         <= '0;
      count_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
      we_q          <= 1'b0;
      wa_q          <= '0;
      di_q          <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      dst_q         <= dst_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
      we_q          <= we_d;
      wa_q          <= wa_d;
      di_q          <= di_d;
    end
  end

endmodule

// File: doc/icache_fill_unit.md
Name: icache_fill_unit

Overview:
- Fills the instruction cache RAM from external memory. Each fill is one burst of consecutive instruction words.
- On a start command it issues word read requests to the memory interface, with a bounded number in flight.
- In-order responses are written into the cache RAM through its single write port (wa/we/di).
- Sits directly upstream of the instruction-cache block RAM write port; the fetch logic owns the read port.

Parameters:
DATA_WIDTH, 32, instruction word width; equals the cache RAM data width
ADDR_WIDTH, 10, cache RAM address bits; equals the cache RAM address width
MEM_ADDR_WIDTH, 32, external memory word-address width
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered memory requests (power of 2, >=1)

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  fill command; sampled only in IDLE
base_addr  input  MEM_ADDR_WIDTH  first memory word address of the burst
dst_addr  input  ADDR_WIDTH  first cache RAM entry to write
count  input  ADDR_WIDTH+1  number of words to fill; 0 to 2^ADDR_WIDTH
busy  output  1  fill in progress
done  output  1  one-cycle pulse when the fill completes
mem_req_valid  output  1  memory read request valid
mem_req_ready  input  1  memory accepts the request
mem_req_addr  output  MEM_ADDR_WIDTH  request word address
mem_rsp_valid  input  1  read data valid; in order, no backpressure
mem_rsp_data  input  DATA_WIDTH  read data
wa  output  ADDR_WIDTH  cache RAM write address
we  output  1  cache RAM write enable
di  output  DATA_WIDTH  cache RAM write data

Behaviour:
- Reset: state=IDLE. busy, done, mem_req_valid, we all 0. wa, di, mem_req_addr and all internal counters 0.
- States:
  - IDLE: busy=0, mem_req_valid=0.
    - start=1 with count!=0: latch base_addr/dst_addr/count, clear issued/received/outstanding, go FILL.
    - start=1 with count==0: go DONE_ZERO.
  - DONE_ZERO: done=1 for exactly one cycle, busy=0, no requests issued, no writes. Then IDLE.
  - FILL: busy=1.
- Timing: start sampled at edge k gives busy=1 in cycle k+1. start while busy is ignored; the latched parameters do not change mid-fill.
- Request side (FILL):
  - mem_req_valid = (issued < count) && (outstanding < MAX_OUTSTANDING).
  - mem_req_addr = base + issued, modulo 2^MEM_ADDR_WIDTH.
  - A handshake (valid && ready) increments issued and outstanding.
  - Once asserted, valid and addr hold stable until the handshake.
- Outstanding counter: request handshake only gives +1; response only gives -1; both in the same cycle leaves it unchanged. It never exceeds MAX_OUTSTANDING.
- Response side (FILL, outstanding!=0): mem_rsp_valid at edge m gives a registered write in cycle m+1:
  - we=1;
  - wa = (dst + received) mod 2^ADDR_WIDTH; cache addresses wrap past the top entry;
  - di = mem_rsp_data.
  - received then increments.
- we is 0 in every cycle with no write; wa and di hold their last values.
- Completion: the response making received==count is accepted at edge m. In cycle m+1: final we=1, done=1, busy=0, state=IDLE. A new start may be sampled in that same cycle m+1.
- Stray responses: mem_rsp_valid while IDLE, or while outstanding==0, is ignored (no write, no counter change).
- Reset mid-fill: all state cleared per the reset values on the next edge, with no done pulse. Responses still in flight from the aborted fill arrive while IDLE and are dropped.
- count=2^ADDR_WIDTH fills the entire RAM exactly once. No entry is written twice; the wrap from dst applies.

Test Plan:
- count=4, base=0x100, dst=0x3F0, ready=1, responses 2 cycles after each request -> requests to 0x100..0x103; writes to 0x3F0..0x3F3 with matching data; single done pulse in the same cycle as the final we; busy=0 there.
- count=3, dst=0x3FE, ADDR_WIDTH=10 -> writes to 0x3FE, 0x3FF, 0x000 (wrap).
- MAX_OUTSTANDING=4, count=8, responses withheld -> exactly 4 request handshakes and then mem_req_valid=0. Releasing one response gives exactly one further request. mem_req_addr stays stable while ready=0.
- start with count=0 -> done=1 one cycle after start, no mem_req_valid, no we, busy stays 0.
- rst asserted after 2 of 6 writes, then 2 late responses delivered -> outputs at reset values, no we, no done. A fresh start with count=2 completes normally.
- start pulsed during FILL with different base_addr, plus a stray mem_rsp_valid while IDLE -> ignored; the original burst's addresses and data are unaffected.
